mmio_arbiter: RTL

MMIO_ARBITER -- requirements
Module: mmio_arbiter

---
 rtl/mmio_arbiter.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/mmio_arbiter.sv
// Two-master round-robin MMIO arbiter with one pending slot per master.
// Define ARB_TIMEOUT_EN to add a WAIT-state watchdog that completes with 32'hDEADBEEF and sets err.
module mmio_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] m0_a,
  input  logic [31:0] m1_a,
  input  logic [31:0] m0_d,
  input  logic [31:0] m1_d,
  input  logic        m0_we,
  input  logic        m1_we,
  input  logic        m0_rd,
  input  logic        m1_rd,
  output logic [31:0] m0_spo,
  output logic [31:0] m1_spo,
  output logic        m0_ready,
  output logic        m1_ready,
  output logic [31:0] s_a,
  output logic [31:0] s_d,
  output logic        s_we,
  output logic        s_rd,
  input  logic [31:0] s_spo,
  input  logic        s_ready,
  output logic        grant,
  output logic        busy,
  output logic        err
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t           state_q;
  logic [1:0]       pend_q;
  logic [1:0]       kind_we_q;
  logic [1:0][31:0] slot_a_q;
  logic [1:0][31:0] slot_d_q;
  logic [1:0][31:0] spo_q;
  logic [31:0]      s_a_q;
  logic [31:0]      s_d_q;
  logic             s_we_q;
  logic             s_rd_q;
  logic             grant_q;
  logic [1:0]       req_d;
  logic [1:0]       accept_d;
  logic             sel_d;
  logic             done_d;
  logic [31:0]      done_spo_d;

  assign req_d    = {m1_we | m1_rd, m0_we | m0_rd};
  assign accept_d = req_d & ~pend_q;

  // Round-robin only matters when both slots are full; otherwise take whoever is pending.
  always_comb begin
    sel_d = pend_q[1];
    if (&pend_q) sel_d = ~grant_q;
  end

`ifdef ARB_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;

  logic [CW-1:0] cnt_q;
  logic          err_q;
  logic          timeout_d;

  assign timeout_d = (state_q == WAIT) && !s_ready && (cnt_q == CW'(TIMEOUT_CYC - 1));

  always_comb begin
    done_d     = (state_q == WAIT) && (s_ready || timeout_d);
    done_spo_d = s_spo;
    if (timeout_d) done_spo_d = 32'hDEADBEEF;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (state_q == ISSUE)     cnt_q <= '0;
      else if (state_q == WAIT) cnt_q <= cnt_q + 1'b1;
      if (timeout_d) err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign done_d     = (state_q == WAIT) && s_ready;
  assign done_spo_d = s_spo;
  assign err        = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pend_q    <= '0;
      kind_we_q <= '0;
      slot_a_q  <= '0;
      slot_d_q  <= '0;
      spo_q     <= '0;
      s_a_q     <= '0;
      s_d_q     <= '0;
      s_we_q    <= 1'b0;
      s_rd_q    <= 1'b0;
      grant_q   <= 1'b1;
    end else begin
      s_we_q <= 1'b0;
      s_rd_q <= 1'b0;
      if (accept_d[0]) begin
        pend_q[0]    <= 1'b1;
        slot_a_q[0]  <= m0_a;
        slot_d_q[0]  <= m0_d;
        kind_we_q[0] <= m0_we;
      end
      if (accept_d[1]) begin
        pend_q[1]    <= 1'b1;
        slot_a_q[1]  <= m1_a;
        slot_d_q[1]  <= m1_d;
        kind_we_q[1] <= m1_we;
      end
      case (state_q)
        IDLE: begin
          if (|pend_q) begin
            grant_q <= sel_d;
            s_a_q   <= slot_a_q[sel_d];
            s_d_q   <= slot_d_q[sel_d];
            s_we_q  <= kind_we_q[sel_d];
            s_rd_q  <= ~kind_we_q[sel_d];
            state_q <= ISSUE;
          end
        end
        ISSUE: state_q <= WAIT;
        WAIT: begin
          // The granted slot is full, so a same-cycle strobe from it was never accepted.
          if (done_d) begin
            spo_q[grant_q]  <= done_spo_d;
            pend_q[grant_q] <= 1'b0;
            state_q         <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m0_ready = ~pend_q[0] & ~req_d[0];
  assign m1_ready = ~pend_q[1] & ~req_d[1];
  assign m0_spo   = spo_q[0];
  assign m1_spo   = spo_q[1];
  assign s_a      = s_a_q;
  assign s_d      = s_d_q;
  assign s_we     = s_we_q;
  assign s_rd     = s_rd_q;
  assign grant    = grant_q;
  assign busy     = (state_q != IDLE);
endmodule
